// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and stage-entry layout for the pipeline tracker.
//   REG_ADDR_W   - architectural register address width
//   FWD_SEL_W    - width of one forwarding-select field
//   FWD_RF       - forwarding-select value meaning "read the register file"
//   stage_ctrl_t - control fields of one stage entry (valid, load, wen, rd);
//                  the WIDTH-bit payload travels beside it since its width is
//                  a parameter of the tracker.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_SEL_W  = 4;
  localparam logic [FWD_SEL_W-1:0] FWD_RF = '0;

  typedef struct packed {
    logic                  valid;
    logic                  load;
    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: entry handshake into the pipeline tracker.
//   in_valid/in_ready - valid/ready handshake, accepted when both are high
//   in_data           - WIDTH-bit payload
//   in_rd/in_wen      - destination register and its write enable
//   in_load           - entry is a load
// Modports: master (producer of entries), slave (the tracker).
interface pipe_ctrl_if import pipe_pkg::*; #(
  parameter int WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_wen;
  logic                  in_load;

  modport master (
    output in_valid, in_data, in_rd, in_wen, in_load,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_wen, in_load,
    output in_ready
  );
endinterface

// File: rtl/pipe_fwd_match.sv
// pipe_fwd_match: combinational youngest-match priority encoder for one read
// port. Finds the youngest stage that is valid, writes a register and targets
// q_addr.
//   stage_valid/wen/load - per-stage flags, bit s-1 is stage s
//   stage_rd             - per-stage destination, stage s at [5s-1:5(s-1)]
//   q_addr               - queried source register (0 never matches)
//   sel                  - matching stage number, or FWD_RF when none
//   hit_load             - the matching stage holds a load
module pipe_fwd_match import pipe_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            stage_valid,
  input  logic [DEPTH-1:0]            stage_wen,
  input  logic [DEPTH-1:0]            stage_load,
  input  logic [DEPTH*REG_ADDR_W-1:0] stage_rd,
  input  logic [REG_ADDR_W-1:0]       q_addr,
  output logic [FWD_SEL_W-1:0]        sel,
  output logic                        hit_load
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel      = FWD_RF;
    hit_load = 1'b0;
    if (q_addr != '0) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (stage_valid[s] && stage_wen[s] &&
            stage_rd[s*REG_ADDR_W +: REG_ADDR_W] == q_addr) begin
          sel      = FWD_SEL_W'(s + 1);
          hit_load = stage_load[s];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: DEPTH-stage in-order pipeline tracker with load-use bubbles,
// external stall, partial flush and NREAD forwarding-select ports.
//   clk, rst_n   - clock, asynchronous active-low reset
//   up           - entry handshake (pipe_ctrl_if.slave)
//   q_addr       - per-port source register, port i at [5i+4:5i]
//   fwd_sel      - per-port forwarding stage (0 = register file)
//   hazard_o     - load-use bubble inserted this cycle
//   stall_i      - freeze all stages
//   flush_i      - clear stages 1..flush_upto (0 treated as 1)
//   stage_valid  - valid bit per stage
//   stage_data   - payload per stage, stage s at [WIDTH*s-1:WIDTH*(s-1)]
//   retire_o     - stage DEPTH entry leaves the pipe this cycle
// Optional macro PIPE_CTRL_PERF_EN adds saturating 32-bit counters
// perf_stall, perf_bubble, perf_flush and perf_retire.
module pipe_ctrl import pipe_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int NREAD      = 2,
  parameter int LOAD_STAGE = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipe_ctrl_if.slave                    up,
  input  logic [NREAD*REG_ADDR_W-1:0]   q_addr,
  output logic [NREAD*FWD_SEL_W-1:0]    fwd_sel,
  output logic                          hazard_o,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic [2:0]                    flush_upto,
  output logic [DEPTH-1:0]              stage_valid,
  output logic [DEPTH*WIDTH-1:0]        stage_data,
  output logic                          retire_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_stall,
  output logic [31:0]                   perf_bubble,
  output logic [31:0]                   perf_flush,
  output logic [31:0]                   perf_retire
`endif
);

  localparam logic [FWD_SEL_W-1:0] LOAD_SEL = FWD_SEL_W'(LOAD_STAGE);

  stage_ctrl_t      ctrl_q   [DEPTH];
  logic [WIDTH-1:0] data_q   [DEPTH];
  stage_ctrl_t      cur_ctrl [DEPTH];
  logic [WIDTH-1:0] cur_data [DEPTH];
  stage_ctrl_t      nxt_ctrl [DEPTH];
  logic [WIDTH-1:0] nxt_data [DEPTH];

  logic [DEPTH-1:0]            vld_vec;
  logic [DEPTH-1:0]            wen_vec;
  logic [DEPTH-1:0]            load_vec;
  logic [DEPTH*REG_ADDR_W-1:0] rd_vec;
  logic [FWD_SEL_W-1:0]        port_sel [NREAD];
  logic [NREAD-1:0]            port_load;
  logic                        load_hit;
  logic                        accept;
  logic [2:0]                  upto_eff;
  logic                        full_flush;

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      vld_vec[s]                           = ctrl_q[s].valid;
      wen_vec[s]                           = ctrl_q[s].wen;
      load_vec[s]                          = ctrl_q[s].load;
      rd_vec[s*REG_ADDR_W +: REG_ADDR_W]   = ctrl_q[s].rd;
      stage_valid[s]                       = ctrl_q[s].valid;
      stage_data[s*WIDTH +: WIDTH]         = data_q[s];
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    pipe_fwd_match #(.DEPTH(DEPTH)) u_match (
      .stage_valid (vld_vec),
      .stage_wen   (wen_vec),
      .stage_load  (load_vec),
      .stage_rd    (rd_vec),
      .q_addr      (q_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .sel         (port_sel[g]),
      .hit_load    (port_load[g])
    );
    assign fwd_sel[g*FWD_SEL_W +: FWD_SEL_W] = port_sel[g];
  end

  // A consumer must wait while its producing load sits younger than the
  // stage where load data first becomes forwardable.
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (port_load[i] && port_sel[i] != FWD_RF && port_sel[i] < LOAD_SEL)
        load_hit = 1'b1;
    end
  end

  assign hazard_o    = load_hit && !stall_i && !flush_i;
  assign up.in_ready = !stall_i && !flush_i && !hazard_o;
  assign accept      = up.in_valid && up.in_ready;

  assign upto_eff   = (flush_upto == 3'd0) ? 3'd1 : flush_upto;
  assign full_flush = flush_i && (int'(upto_eff) >= DEPTH);
  assign retire_o   = ctrl_q[DEPTH-1].valid && !stall_i && !full_flush;

  // Flushed slots are cleared before the shift, so a killed entry never
  // reappears one stage deeper; the stage just past the flush window
  // receives a bubble instead.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      cur_ctrl[s] = ctrl_q[s];
      cur_data[s] = data_q[s];
      if (flush_i && s < int'(upto_eff)) begin
        cur_ctrl[s] = '0;
        cur_data[s] = '0;
      end
    end
    nxt_ctrl = cur_ctrl;
    nxt_data = cur_data;
    if (!stall_i) begin
      if (accept) begin
        nxt_ctrl[0] = '{valid: 1'b1, load: up.in_load, wen: up.in_wen, rd: up.in_rd};
        nxt_data[0] = up.in_data;
      end else begin
        nxt_ctrl[0] = '0;
        nxt_data[0] = '0;
      end
      for (int s = 1; s < DEPTH; s++) begin
        nxt_ctrl[s] = cur_ctrl[s-1];
        nxt_data[s] = cur_data[s-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        ctrl_q[s] <= '0;
        data_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        ctrl_q[s] <= nxt_ctrl[s];
        data_q[s] <= nxt_data[s];
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
      perf_retire <= '0;
    end else begin
      if (stall_i)  perf_stall  <= sat_inc(perf_stall);
      if (hazard_o) perf_bubble <= sat_inc(perf_bubble);
      if (flush_i)  perf_flush  <= sat_inc(perf_flush);
      if (retire_o) perf_retire <= sat_inc(perf_retire);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl (DEPTH 4, NREAD 2, LOAD_STAGE 3).
module tb_pipe_ctrl;
  import pipe_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [9:0]   q_addr;
  logic [7:0]   fwd_sel;
  logic         hazard_o;
  logic         stall_i;
  logic         flush_i;
  logic [2:0]   flush_upto;
  logic [3:0]   stage_valid;
  logic [127:0] stage_data;
  logic         retire_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]  perf_stall, perf_bubble, perf_flush, perf_retire;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl_if #(.WIDTH(32)) bus ();

  pipe_ctrl #(.WIDTH(32), .DEPTH(4), .NREAD(2), .LOAD_STAGE(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up          (bus),
    .q_addr      (q_addr),
    .fwd_sel     (fwd_sel),
    .hazard_o    (hazard_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .flush_upto  (flush_upto),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .retire_o    (retire_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_bubble (perf_bubble),
    .perf_flush  (perf_flush),
    .perf_retire (perf_retire)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input logic wen, input logic ld);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_rd    = rd;
    bus.in_wen   = wen;
    bus.in_load  = ld;
  endtask

  initial begin
    rst_n      = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    flush_upto = 3'd0;
    q_addr     = '0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    #3;
    chk("rst_valid", 128'(stage_valid), 128'h0);
    chk("rst_data", stage_data, 128'h0);
    chk("rst_retire", 128'(retire_o), 128'h0);
    chk("rst_fwd", 128'(fwd_sel), 128'h0);
    chk("rst_ready", 128'(bus.in_ready), 128'h1);
    chk("rst_hazard", 128'(hazard_o), 128'h0);
    #9 rst_n = 1'b1;
    tick();

    // Stream of five entries 0x11..0x15.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'h10 + 32'(k), 5'(k), 1'b0, 1'b0);
      #1;
      chk("stream_ready", 128'(bus.in_ready), 128'h1);
      tick();
      chk("stream_valid", 128'(stage_valid), (k >= 4) ? 128'hF : 128'((1 << k) - 1));
      chk("stream_retire", 128'(retire_o), (k >= 4) ? 128'h1 : 128'h0);
    end
    chk("stream_data", stage_data, {32'h12, 32'h13, 32'h14, 32'h15});

    // Stall a full pipe for three cycles.
    stall_i = 1'b1;
    drive(1'b1, 32'h99, 5'd1, 1'b0, 1'b0);
    #1;
    chk("stall_ready", 128'(bus.in_ready), 128'h0);
    chk("stall_retire", 128'(retire_o), 128'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_data", stage_data, {32'h12, 32'h13, 32'h14, 32'h15});
      chk("stall_valid", 128'(stage_valid), 128'hF);
      chk("stall_retire_hold", 128'(retire_o), 128'h0);
    end

    // Partial flush of stages 1..2 while stalled.
    flush_i    = 1'b1;
    flush_upto = 3'd2;
    drive(1'b1, 32'h77, 5'd2, 1'b0, 1'b0);
    #1;
    chk("flush_ready", 128'(bus.in_ready), 128'h0);
    tick();
    chk("flush2_valid", 128'(stage_valid), 128'hC);
    chk("flush2_data", stage_data, {32'h12, 32'h13, 64'h0});

    // flush_upto = 0 behaves as 1; deeper stages advance.
    stall_i    = 1'b0;
    flush_upto = 3'd0;
    #1;
    chk("flush0_retire", 128'(retire_o), 128'h1);
    chk("flush0_ready", 128'(bus.in_ready), 128'h0);
    tick();
    chk("flush0_valid", 128'(stage_valid), 128'h8);
    chk("flush0_data", stage_data, {32'h13, 96'h0});

    // Whole-pipe flush suppresses retire.
    flush_upto = 3'd7;
    #1;
    chk("flushall_retire", 128'(retire_o), 128'h0);
    tick();
    chk("flushall_valid", 128'(stage_valid), 128'h0);
    chk("flushall_data", stage_data, 128'h0);
    flush_i    = 1'b0;
    flush_upto = 3'd0;

    // Forwarding: A(rd5) -> stage 3, B(rd5) -> stage 2, C(rd9) -> stage 1.
    drive(1'b1, 32'h21, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h22, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h23, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    q_addr = {5'd9, 5'd5};
    #1;
    chk("fwd_youngest", 128'(fwd_sel), 128'h12);
    chk("fwd_nohazard", 128'(hazard_o), 128'h0);
    q_addr = {5'd0, 5'd0};
    #1;
    chk("fwd_zero", 128'(fwd_sel), 128'h0);
    q_addr = {5'd0, 5'd3};
    #1;
    chk("fwd_miss", 128'(fwd_sel), 128'h0);

    // Load-use: load rd7, then a consumer reading r7.
    q_addr = '0;
    drive(1'b1, 32'h31, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h32, 5'd8, 1'b1, 1'b0);
    q_addr = {5'd0, 5'd7};
    #1;
    chk("lu1_hazard", 128'(hazard_o), 128'h1);
    chk("lu1_ready", 128'(bus.in_ready), 128'h0);
    chk("lu1_fwd", 128'(fwd_sel), 128'h01);
    tick();
    chk("lu2_valid", 128'(stage_valid), 128'hE);
    chk("lu2_bubble_data", 128'(stage_data[31:0]), 128'h0);
    chk("lu2_hazard", 128'(hazard_o), 128'h1);
    chk("lu2_fwd", 128'(fwd_sel), 128'h02);
    tick();
    chk("lu3_valid", 128'(stage_valid), 128'hC);
    chk("lu3_hazard", 128'(hazard_o), 128'h0);
    chk("lu3_ready", 128'(bus.in_ready), 128'h1);
    chk("lu3_fwd", 128'(fwd_sel), 128'h03);
    tick();
    chk("lu4_valid", 128'(stage_valid), 128'h9);
    chk("lu4_s1_data", 128'(stage_data[31:0]), 128'h32);
    chk("lu4_s4_data", 128'(stage_data[127:96]), 128'h31);
    chk("lu4_fwd", 128'(fwd_sel), 128'h04);

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(stage_valid), 128'h0);
    chk("arst_data", stage_data, 128'h0);
    chk("arst_retire", 128'(retire_o), 128'h0);
    chk("arst_fwd", 128'(fwd_sel), 128'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("arst_perf_stall", 128'(perf_stall), 128'h0);
    chk("arst_perf_bubble", 128'(perf_bubble), 128'h0);
    chk("arst_perf_flush", 128'(perf_flush), 128'h0);
    chk("arst_perf_retire", 128'(perf_retire), 128'h0);
`endif
    #2 rst_n = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("post_rst_valid", 128'(stage_valid), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
